// File: rtl/aux_fifo_writer.sv
// HDMI aux capture: registers TERC4 aux words during ADE and pushes {timestamp, aux} into the aux send FIFO.
// Bursts are tagged with their starting hcnt; per-line burst count and sticky overflow are reported.
module aux_fifo_writer #(
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned HW        = 11,
    parameter int unsigned TSW       = 12
) (
    input  logic             fifo_clk,
    input  logic             sys_rst_n,
    input  logic             ade,
    input  logic             vde,
    input  logic [HW-1:0]    hcnt,
    input  logic [11:0]      aux,
    input  logic             fifo_full,
    output logic [TSW+11:0]  fifo_din,
    output logic             fifo_wr_en,
    output logic [3:0]       ade_num,
    output logic             ade_num_vld,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned    BCW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCW-1:0] LAST_IDX = BCW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DROP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_ade1;
    logic            r_vde1;
    logic [11:0]     r_aux1;
    logic [HW-1:0]   r_hcnt1;
    logic            r_s1_vld;

    logic [TSW-1:0]  r_ts;
    logic [TSW-1:0]  w_ts_nxt;
    logic [BCW-1:0]  r_bcnt;
    logic [BCW-1:0]  w_bcnt_nxt;
    logic [3:0]      r_line_bursts;

    logic            w_ade;
    logic            w_last;
    logic            w_wr;
    logic            w_done;
    logic            w_ovf;
    logic            w_line_start;

    always_ff @(posedge fifo_clk) begin
        if (!sys_rst_n) begin
            r_ade1   <= 1'b0;
            r_vde1   <= 1'b0;
            r_aux1   <= '0;
            r_hcnt1  <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_ade1   <= ade;
            r_vde1   <= vde;
            r_aux1   <= aux;
            r_hcnt1  <= hcnt;
            r_s1_vld <= 1'b1;
        end
    end

    // ade has priority over a concurrent vde; the overlap is captured as aux data
    assign w_ade        = r_ade1 | (r_ade1 & r_vde1);
    assign w_last       = (r_bcnt == LAST_IDX);
    // r_s1_vld masks the reset value of r_hcnt1 so no spurious line pulse follows reset
    assign w_line_start = r_s1_vld && (r_hcnt1 == '0);
    assign busy         = (r_state != S_IDLE);

    // r_bcnt holds the index of the word about to be consumed in the current burst
    always_comb begin
        w_state_nxt = r_state;
        w_ts_nxt    = r_ts;
        w_bcnt_nxt  = r_bcnt;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        w_ovf       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ade) begin
                    w_ts_nxt   = TSW'(r_hcnt1);
                    w_bcnt_nxt = BCW'(1);
                    if (!fifo_full) begin
                        w_wr        = 1'b1;
                        w_state_nxt = S_BURST;
                    end else begin
                        w_ovf       = 1'b1;
                        w_state_nxt = S_DROP;
                    end
                end
            end
            S_BURST: begin
                if (!w_ade) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (fifo_full) begin
                    w_ovf = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + BCW'(1);
                        w_state_nxt = S_DROP;
                    end
                end else begin
                    w_wr = 1'b1;
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bcnt_nxt = r_bcnt + BCW'(1);
                    end
                end
            end
            S_DROP: begin
                if (!w_ade || w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_bcnt_nxt = r_bcnt + BCW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge fifo_clk) begin
        if (!sys_rst_n) begin
            r_state       <= S_IDLE;
            r_ts          <= '0;
            r_bcnt        <= '0;
            r_line_bursts <= '0;
            fifo_din      <= '0;
            fifo_wr_en    <= 1'b0;
            ade_num       <= '0;
            ade_num_vld   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ts        <= w_ts_nxt;
            r_bcnt      <= w_bcnt_nxt;
            fifo_wr_en  <= w_wr;
            ade_num_vld <= w_line_start;
            if (w_wr) begin
                fifo_din <= {w_ts_nxt, r_aux1};
            end
            if (w_ovf) begin
                overflow <= 1'b1;
            end
            // a burst finishing on the line-start cycle belongs to the new line
            if (w_line_start) begin
                ade_num       <= r_line_bursts;
                r_line_bursts <= w_done ? 4'd1 : 4'd0;
            end else if (w_done && (r_line_bursts != 4'hF)) begin
                r_line_bursts <= r_line_bursts + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aux_fifo_writer.sv
// Bench for aux_fifo_writer: directed table, saturation run, random run against a burst-level model,
// and a hand-written reset-mid-burst sequence.
`timescale 1ns/1ps
module tb_aux_fifo_writer;

    localparam int BL   = 32;
    localparam int MAXC = 16384;

    logic        clk;
    logic        rst_n;
    logic        ade;
    logic        vde;
    logic [10:0] hcnt;
    logic [11:0] aux;
    logic        fifo_full;
    logic [23:0] fifo_din;
    logic        fifo_wr_en;
    logic [3:0]  ade_num;
    logic        ade_num_vld;
    logic        overflow;
    logic        busy;

    aux_fifo_writer #(.BURST_LEN(32), .HW(11), .TSW(12)) dut (
        .fifo_clk    (clk),
        .sys_rst_n   (rst_n),
        .ade         (ade),
        .vde         (vde),
        .hcnt        (hcnt),
        .aux         (aux),
        .fifo_full   (fifo_full),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .ade_num     (ade_num),
        .ade_num_vld (ade_num_vld),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // per-cycle stimulus (index c = cycle the inputs are applied) and expected outputs for that index
    logic        s_ade  [MAXC];
    logic        s_vde  [MAXC];
    logic [11:0] s_aux  [MAXC];
    logic [10:0] s_hcnt [MAXC];
    logic        s_full [MAXC];
    logic        e_wr   [MAXC];
    logic [23:0] e_din  [MAXC];
    logic        e_vld  [MAXC];
    logic [3:0]  e_num  [MAXC];
    logic        e_ovf  [MAXC];
    bit          ovf_at [MAXC];
    bit          done_at[MAXC];
    int          nc;

    int          st_wr, st_first_j, st_pulses, st_last_num, st_min_num;
    logic [23:0] st_first, st_last;
    logic        st_ovf;

    typedef struct {
        string       name;
        int          line;
        int          h0;
        int          ncyc;
        int          ade_h;
        int          ade_len;
        int          full_off;
        int          full_len;
        int          exp_wr;
        logic [23:0] exp_first;
        logic [23:0] exp_last;
        int          exp_num;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; ade = 1'b0; vde = 1'b0; fifo_full = 1'b0; hcnt = 11'd1; aux = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst.wr_en",   32'(fifo_wr_en),  32'd0);
        chk("rst.din",     32'(fifo_din),    32'd0);
        chk("rst.ade_num", 32'(ade_num),     32'd0);
        chk("rst.vld",     32'(ade_num_vld), 32'd0);
        chk("rst.ovf",     32'(overflow),    32'd0);
        chk("rst.busy",    32'(busy),        32'd0);
        rst_n = 1'b1;
    endtask

    // Reference: split each contiguous ade run into BL-word chunks from its first cycle.
    // A chunk writes words until the first full; any full drops the rest and the chunk is not counted.
    task automatic build_expected();
        int c, rs, re, ke, d, line_cnt;
        logic dropped, ovf;
        logic [10:0] ts;
        logic [3:0] num;
        for (int i = 0; i < nc; i++) begin
            e_wr[i] = 1'b0; e_din[i] = '0; ovf_at[i] = 1'b0; done_at[i] = 1'b0;
        end
        c = 0;
        while (c < nc) begin
            if (!s_ade[c]) begin
                c++;
                continue;
            end
            rs = c;
            re = c;
            while (re < nc && s_ade[re]) re++;
            for (int k = rs; k < re; k += BL) begin
                ke = (k + BL < re) ? k + BL : re;
                ts = s_hcnt[k];
                dropped = 1'b0;
                for (int w = k; w < ke; w++) begin
                    if (!dropped && s_full[w]) begin
                        dropped = 1'b1;
                        ovf_at[w] = 1'b1;
                    end
                    if (!dropped) begin
                        e_wr[w]  = 1'b1;
                        e_din[w] = {1'b0, ts, s_aux[w]};
                    end
                end
                if (!dropped) begin
                    d = (ke - k == BL) ? ke - 1 : ke;
                    if (d < nc) done_at[d] = 1'b1;
                end
            end
            c = re;
        end
        line_cnt = 0; num = '0; ovf = 1'b0;
        for (int i = 0; i < nc; i++) begin
            if (ovf_at[i]) ovf = 1'b1;
            e_ovf[i] = ovf;
            if (s_hcnt[i] == 11'd0) begin
                e_vld[i] = 1'b1;
                num = 4'(line_cnt);
                line_cnt = done_at[i] ? 1 : 0;
            end else begin
                e_vld[i] = 1'b0;
                if (done_at[i] && line_cnt < 15) line_cnt++;
            end
            e_num[i] = num;
        end
    endtask

    task automatic run_stim();
        int idx;
        st_wr = 0; st_first_j = -1; st_first = '0; st_last = '0;
        st_pulses = 0; st_last_num = -1; st_min_num = 99;
        for (int j = 0; j < nc + 2; j++) begin
            @(posedge clk); #1;
            if (j >= 2) begin
                idx = j - 2;
                chk("cyc.wr_en", 32'(fifo_wr_en), 32'(e_wr[idx]));
                if (e_wr[idx]) chk("cyc.din", 32'(fifo_din), 32'(e_din[idx]));
                chk("cyc.vld", 32'(ade_num_vld), 32'(e_vld[idx]));
                chk("cyc.ade_num", 32'(ade_num), 32'(e_num[idx]));
                chk("cyc.ovf", 32'(overflow), 32'(e_ovf[idx]));
                if (fifo_wr_en) begin
                    if (st_wr == 0) begin
                        st_first_j = j;
                        st_first   = fifo_din;
                    end
                    st_last = fifo_din;
                    st_wr++;
                end
                if (ade_num_vld) begin
                    st_pulses++;
                    st_last_num = int'(ade_num);
                    if (int'(ade_num) < st_min_num) st_min_num = int'(ade_num);
                end
            end
            if (j < nc) begin
                ade = s_ade[j]; aux = s_aux[j]; hcnt = s_hcnt[j]; vde = s_vde[j];
            end else begin
                ade = 1'b0;
            end
            fifo_full = (j >= 1 && j <= nc) ? s_full[j-1] : 1'b0;
        end
        st_ovf = overflow;
    endtask

    task automatic build_table(input vec_t v, output int a_start);
        int h, off;
        logic inb;
        a_start = (v.ade_h + v.line - v.h0) % v.line;
        nc = v.ncyc;
        for (int c = 0; c < nc; c++) begin
            h   = (v.h0 + c) % v.line;
            off = c - a_start;
            inb = (c >= a_start) && (c < a_start + v.ade_len);
            s_hcnt[c] = 11'(h);
            s_ade[c]  = inb;
            s_aux[c]  = inb ? 12'(off) : 12'($urandom);
            s_full[c] = inb && (off >= v.full_off) && (off < v.full_off + v.full_len);
            s_vde[c]  = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[6];
        int a_start;
        rst_n = 1'b0; ade = 1'b0; vde = 1'b0; hcnt = '0; aux = '0; fifo_full = 1'b0;

        tv[0] = '{"single32",  200,   95, 115,  100, 32, 0,  0, 32, 24'h064000, 24'h06401F, 1, 1'b0};
        tv[1] = '{"contig96",  200,  198, 206,    1, 96, 0,  0, 96, 24'h001000, 24'h04105F, 3, 1'b0};
        tv[2] = '{"full_start",200,   45, 159,   50, 32, 0,  5,  0, 24'h000000, 24'h000000, 0, 1'b1};
        tv[3] = '{"full_w10",  200,   15, 189,   20, 64, 10, 1, 42, 24'h014000, 24'h03403F, 1, 1'b1};
        tv[4] = '{"short7",    200,    5, 200,   10,  7, 0,  0,  7, 24'h00A000, 24'h00A006, 1, 1'b0};
        tv[5] = '{"hcnt_max", 2048, 2040,  12, 2047,  1, 0,  0,  1, 24'h7FF000, 24'h7FF000, 0, 1'b0};

        for (int t = 0; t < 6; t++) begin
            do_reset();
            build_table(tv[t], a_start);
            build_expected();
            run_stim();
            chk($sformatf("%s.writes", tv[t].name), 32'(st_wr), 32'(tv[t].exp_wr));
            if (tv[t].exp_wr > 0) begin
                chk($sformatf("%s.first", tv[t].name), 32'(st_first), 32'(tv[t].exp_first));
                chk($sformatf("%s.last", tv[t].name), 32'(st_last), 32'(tv[t].exp_last));
                chk($sformatf("%s.latency", tv[t].name), 32'(st_first_j - a_start), 32'd2);
            end
            chk($sformatf("%s.ade_num", tv[t].name), 32'(st_last_num), 32'(tv[t].exp_num));
            chk($sformatf("%s.ovf", tv[t].name), 32'(st_ovf), 32'(tv[t].exp_ovf));
        end

        // 20 lines of 15 bursts then one line of 17: every line reports 15
        do_reset();
        nc = 12605;
        for (int c = 0; c < nc; c++) begin
            int h, li, nb;
            h  = (1 + c) % 600;
            li = (c + 1) / 600;
            nb = (li < 20) ? 15 : ((li == 20) ? 17 : 0);
            s_hcnt[c] = 11'(h);
            s_ade[c]  = (h >= 10) && (h < 10 + nb * BL);
            s_aux[c]  = 12'($urandom);
            s_full[c] = 1'b0;
            s_vde[c]  = 1'($urandom_range(0, 1));
        end
        build_expected();
        run_stim();
        chk("sat.pulses", 32'(st_pulses), 32'd21);
        chk("sat.min_num", 32'(st_min_num), 32'd15);
        chk("sat.last_num", 32'(st_last_num), 32'd15);

        // random runs of ade with sporadic fifo_full
        do_reset();
        nc = 3000;
        begin
            int hoff, c, gap, len;
            hoff = $urandom_range(0, 299);
            for (int i = 0; i < nc; i++) begin
                s_hcnt[i] = 11'((hoff + i) % 300);
                s_ade[i]  = 1'b0;
                s_aux[i]  = 12'($urandom);
                s_full[i] = ($urandom_range(0, 19) == 0);
                s_vde[i]  = 1'($urandom_range(0, 1));
            end
            c = 0;
            while (c < nc - 110) begin
                gap = $urandom_range(1, 12);
                len = $urandom_range(1, 100);
                c += gap;
                for (int k = 0; k < len; k++) s_ade[c + k] = 1'b1;
                c += len;
            end
        end
        build_expected();
        run_stim();

        // reset asserted while word 16 of a burst is applied, then a clean restart
        do_reset();
        for (int j = 0; j < 22; j++) begin
            @(posedge clk); #1;
            if (j == 18) begin
                chk("rstmid.pre_wr", 32'(fifo_wr_en), 32'd1);
                chk("rstmid.pre_din", 32'(fifo_din), 32'h06400E);
            end
            if (j == 19 || j == 21) begin
                chk("rstmid.wr_en", 32'(fifo_wr_en), 32'd0);
                chk("rstmid.din", 32'(fifo_din), 32'd0);
                chk("rstmid.busy", 32'(busy), 32'd0);
                chk("rstmid.ovf", 32'(overflow), 32'd0);
                chk("rstmid.vld", 32'(ade_num_vld), 32'd0);
            end
            hcnt      = 11'(98 + j);
            ade       = (j >= 2) && (j <= 19);
            aux       = 12'(j - 2);
            fifo_full = 1'b0;
            rst_n     = !((j == 18) || (j == 19));
        end
        for (int j = 0; j < 9; j++) begin
            @(posedge clk); #1;
            if (j == 3) chk("restart.no_early_wr", 32'(fifo_wr_en), 32'd0);
            if (j == 4) begin
                chk("restart.wr_en", 32'(fifo_wr_en), 32'd1);
                chk("restart.din", 32'(fifo_din), 32'h12CA02);
                chk("restart.busy", 32'(busy), 32'd1);
            end
            if (j == 7) chk("restart.last_din", 32'(fifo_din), 32'h12CA05);
            hcnt = 11'(298 + j);
            ade  = (j >= 2) && (j < 6);
            aux  = 12'(12'hA00 + j);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aux_fifo_writer.md
Name: aux_fifo_writer

Overview:
- Capture side of the HDMI auxiliary (audio/InfoFrame) path, feeding the 24-bit aux send FIFO that `gmii_tx` drains.
- Samples the 12-bit TERC4 aux word (`aux2`, `aux1`, `aux0`) on every aux-data-enable cycle.
- Tags each 32-cycle burst with the `hcnt` at which it started, and pushes `{timestamp, aux}` words into the FIFO.
- Reports per-line burst count (`ade_num`) and overflow so the transmitter can frame packets and the receiver can replay ADE at the same horizontal position.

Parameters:
- `BURST_LEN`, 32, aux cycles per ADE burst (power of two, 2..32).
- `HW`, 11, `hcnt` width.
- `TSW`, 12, timestamp field width in FIFO word (≥ `HW`; zero-extended).

Ports:
- `fifo_clk`  in  1  pixel clock, all logic on rising edge
- `sys_rst_n`  in  1  synchronous reset, active-low
- `ade`  in  1  aux data enable from HDMI decoder
- `vde`  in  1  video data enable
- `hcnt`  in  `HW`  horizontal pixel counter, 0 at line start
- `aux`  in  12  `{aux2,aux1,aux0}` decoded aux nibbles
- `fifo_full`  in  1  aux send FIFO full
- `fifo_din`  out  24  `{ts[TSW-1:0], aux[11:0]}`
- `fifo_wr_en`  out  1  write strobe
- `ade_num`  out  4  bursts captured in previous line, saturating
- `ade_num_vld`  out  1  one-cycle pulse when `ade_num` updates
- `overflow`  out  1  sticky: a word or burst was dropped
- `busy`  out  1  FSM not in IDLE

Behaviour:
- Reset (`sys_rst_n`=0 at clock edge): state=IDLE, `fifo_din`=0, `fifo_wr_en`=0, `ade_num`=0, `ade_num_vld`=0, `overflow`=0, burst counters=0. Reset mid-burst aborts immediately; no partial words emitted after reset edge.
- Input registers: `ade`, `aux`, `hcnt` registered once (stage 1); all decisions on stage-1 values. `fifo_wr_en`/`fifo_din` registered (stage 2) → write appears 2 cycles after the sampled `ade` input.
- FSM states: IDLE, BURST, DROP.
  - IDLE: stage-1 `ade`=1 → latch `ts`=stage-1 `hcnt`; `bcnt`=0. If `fifo_full`=0, write word, go BURST. Else set `overflow`, go DROP.
  - BURST: each cycle with stage-1 `ade`=1 → write `{ts, aux}`, `bcnt++`.
    - If `fifo_full`=1 in BURST: that word is not written; `overflow` set; state→DROP.
    - When `bcnt` reaches `BURST_LEN`-1 and is written: `line_bursts++` (saturate 15). Next cycle with `ade`=1 starts a new burst with `ts`=its `hcnt` (back-to-back bursts allowed, no idle cycle needed). `ade`=0 → IDLE.
    - `ade` falls before `BURST_LEN` words: short burst; `line_bursts` still incremented; → IDLE.
  - DROP: no writes; remain until stage-1 `ade`=0 for one cycle, or burst boundary (`bcnt` reaches `BURST_LEN`-1), then IDLE/new burst evaluated as in IDLE (new burst re-checks `fifo_full`). Dropped bursts not counted in `line_bursts`.
- Timestamp: `ts` zero-extended `hcnt` to `TSW`; `hcnt`=2047 stored as 0x7FF.
- Line accounting: stage-1 `hcnt`==0 → `ade_num`<=`line_bursts`, `ade_num_vld`=1 for one cycle, `line_bursts`<=0. A burst completing on the same cycle as `hcnt`==0 is counted into the new line.
- `ade` and `vde` both 1 (illegal): `ade` wins; word captured; no error flag.
- `overflow` clears only on reset.
- `busy`=1 in BURST or DROP.

Test Plan:
- Single 32-cycle `ade` at `hcnt`=100, `aux`=incrementing 0x000..0x01F, `fifo_full`=0 → 32 writes, `fifo_din`=0x064000..0x06401F, first write 2 cycles after `ade` rise. Next `hcnt`=0 → `ade_num`=1 with `ade_num_vld` pulse.
- 96 contiguous `ade` cycles starting `hcnt`=1 → 96 writes; `ts` field 0x001 for words 0-31, 0x021 for 32-63, 0x041 for 64-95. `ade_num`=3 at next line.
- `fifo_full`=1 at burst start (`hcnt`=50), deassert after 5 cycles → zero writes for that burst; `overflow`=1; `ade_num`=0.
- `fifo_full` asserted on word 10 of a burst → exactly 10 words written, remaining 22 dropped, `overflow`=1. Following burst with `full`=0 writes all 32.
- 20 lines × 15 bursts, then one line × 17 bursts → `ade_num`=15 each, saturating at 15 for the 17-burst line.
- `sys_rst_n` low on word 16 of a burst → `fifo_wr_en`=0 from next cycle. All outputs at reset values. Capture restarts cleanly on next `ade` rise with new `ts`.
